// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolution: holds the F->D branch, resolves it against the
// fetch-stage prediction, strobes predictor updates and drives redirect/flush.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_f,
    input  logic [31:0]      pc_plus4_f,
    input  logic             pred_taken_f,
    input  logic [31:0]      pred_target_f,
    input  logic             valid_f,
    input  logic             stall_d,
    input  logic [31:0]      rs_val_d,
    input  logic [31:0]      rt_val_d,
    output logic             Branch_flag_BGEZ,
    output logic             Branch_flag_BLTZ,
    output logic             Branch_flag_BEQ,
    output logic             Branch_flag_BNE,
    output logic             Branch_flag_BLEZ,
    output logic             Branch_flag_BGTZ,
    output logic [5:0]       Branch_taken,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             flush_fd,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    typedef enum logic {
        IDLE,
        RECOVER
    } state_t;

    localparam logic [2:0] RECOVER_LEN = 3'(FLUSH_CYCLES - 1);

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;

    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        pred_taken_d;
    logic [31:0] pred_target_d;
    logic        valid_d;

    logic [5:0]  br_sel;
    logic        is_branch;
    logic        taken;
    logic [31:0] target;
    logic        resolve;
    logic [5:0]  flag_q;
    logic [5:0]  taken_q;

    // rs field is not decoded: its value arrives already forwarded on rs_val_d
    logic        unused_rs_field;
    assign unused_rs_field = ^instr_d[25:21];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_d       <= '0;
            pc_plus4_d    <= '0;
            pred_taken_d  <= 1'b0;
            pred_target_d <= '0;
            valid_d       <= 1'b0;
        end else if (flush_fd) begin
            valid_d       <= 1'b0;
        end else if (!stall_d) begin
            instr_d       <= instr_f;
            pc_plus4_d    <= pc_plus4_f;
            pred_taken_d  <= pred_taken_f;
            pred_target_d <= pred_target_f;
            valid_d       <= valid_f;
        end
    end

    always_comb begin
        br_sel = '0;
        taken  = 1'b0;
        case (instr_d[31:26])
            6'b000001: begin
                if (instr_d[20:16] == 5'b00001) begin
                    br_sel[0] = 1'b1;
                    taken     = !rs_val_d[31];
                end else if (instr_d[20:16] == 5'b00000) begin
                    br_sel[1] = 1'b1;
                    taken     = rs_val_d[31];
                end
            end
            6'b000100: begin
                br_sel[2] = 1'b1;
                taken     = (rs_val_d == rt_val_d);
            end
            6'b000101: begin
                br_sel[3] = 1'b1;
                taken     = (rs_val_d != rt_val_d);
            end
            6'b000110: begin
                br_sel[4] = 1'b1;
                taken     = ($signed(rs_val_d) <= 32'sd0);
            end
            6'b000111: begin
                br_sel[5] = 1'b1;
                taken     = ($signed(rs_val_d) > 32'sd0);
            end
            default: begin
                br_sel = '0;
                taken  = 1'b0;
            end
        endcase
    end

    assign is_branch   = |br_sel;
    assign target      = pc_plus4_d + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign resolve     = valid_d & is_branch & !stall_d & (state == IDLE);
    assign mispredict  = resolve & ((taken != pred_taken_d) |
                                    (taken & (pred_target_d != target)));
    assign redirect_pc = taken ? target : pc_plus4_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The mispredict cycle itself is the first flush cycle, so RECOVER
    // covers the remaining FLUSH_CYCLES-1 cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        flush_fd   = 1'b0;
        case (state)
            IDLE: begin
                flush_fd = mispredict;
                if (mispredict && (FLUSH_CYCLES > 1)) begin
                    state_next = RECOVER;
                    cnt_next   = RECOVER_LEN;
                end
            end
            RECOVER: begin
                flush_fd = 1'b1;
                cnt_next = cnt - 3'd1;
                if (cnt_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q      <= '0;
            taken_q     <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            flag_q  <= resolve ? br_sel : '0;
            taken_q <= (resolve && taken) ? br_sel : '0;
            if (resolve && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

    assign Branch_flag_BGEZ = flag_q[0];
    assign Branch_flag_BLTZ = flag_q[1];
    assign Branch_flag_BEQ  = flag_q[2];
    assign Branch_flag_BNE  = flag_q[3];
    assign Branch_flag_BLEZ = flag_q[4];
    assign Branch_flag_BGTZ = flag_q[5];
    assign Branch_taken     = taken_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: instance A uses default parameters, instance B uses
// FLUSH_CYCLES=3 and CNT_W=4 for the recovery-window and saturation cases.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_f;
    logic [31:0] pc_plus4_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        valid_f;
    logic        stall_d;
    logic [31:0] rs_val_d;
    logic [31:0] rt_val_d;

    logic        a_bgez, a_bltz, a_beq, a_bne, a_blez, a_bgtz;
    logic [5:0]  a_taken;
    logic        a_mis, a_flush;
    logic [31:0] a_redir;
    logic [15:0] a_bcnt, a_mcnt;

    logic        b_bgez, b_bltz, b_beq, b_bne, b_blez, b_bgtz;
    logic [5:0]  b_taken;
    logic        b_mis, b_flush;
    logic [31:0] b_redir;
    logic [3:0]  b_bcnt, b_mcnt;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    branch_resolve_unit u_dut_a (
        .clk(clk), .rst(rst), .instr_f(instr_f), .pc_plus4_f(pc_plus4_f),
        .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f), .valid_f(valid_f),
        .stall_d(stall_d), .rs_val_d(rs_val_d), .rt_val_d(rt_val_d),
        .Branch_flag_BGEZ(a_bgez), .Branch_flag_BLTZ(a_bltz), .Branch_flag_BEQ(a_beq),
        .Branch_flag_BNE(a_bne), .Branch_flag_BLEZ(a_blez), .Branch_flag_BGTZ(a_bgtz),
        .Branch_taken(a_taken), .mispredict(a_mis), .redirect_pc(a_redir),
        .flush_fd(a_flush), .branch_cnt(a_bcnt), .mispred_cnt(a_mcnt)
    );

    branch_resolve_unit #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .instr_f(instr_f), .pc_plus4_f(pc_plus4_f),
        .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f), .valid_f(valid_f),
        .stall_d(stall_d), .rs_val_d(rs_val_d), .rt_val_d(rt_val_d),
        .Branch_flag_BGEZ(b_bgez), .Branch_flag_BLTZ(b_bltz), .Branch_flag_BEQ(b_beq),
        .Branch_flag_BNE(b_bne), .Branch_flag_BLEZ(b_blez), .Branch_flag_BGTZ(b_bgtz),
        .Branch_taken(b_taken), .mispredict(b_mis), .redirect_pc(b_redir),
        .flush_fd(b_flush), .branch_cnt(b_bcnt), .mispred_cnt(b_mcnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {op, 5'd2, rt, imm};
    endfunction

    task automatic set_fetch(input logic [31:0] ins, input logic [31:0] pc4,
                             input logic pt, input logic [31:0] ptgt);
        instr_f       = ins;
        pc_plus4_f    = pc4;
        pred_taken_f  = pt;
        pred_target_f = ptgt;
        valid_f       = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; instr_f = '0; pc_plus4_f = '0; pred_taken_f = 1'b0;
        pred_target_f = '0; valid_f = 1'b0; stall_d = 1'b0; rs_val_d = '0; rt_val_d = '0;
        tick(); tick();
        check_val("rst_flush",  32'(a_flush), 32'd0);
        check_val("rst_mis",    32'(a_mis),   32'd0);
        check_val("rst_taken",  32'(a_taken), 32'd0);
        check_val("rst_bcnt",   32'(a_bcnt),  32'd0);
        check_val("rst_b_flush", 32'(b_flush), 32'd0);
        rst = 1'b1;
        tick();

        // 1: correctly predicted taken BEQ
        set_fetch(mk(OP_BEQ, 5'd3, 16'h0004), 32'h40, 1'b1, 32'h50);
        tick();
        valid_f = 1'b0; rs_val_d = 32'd5; rt_val_d = 32'd5; #1;
        check_val("t1_mis",   32'(a_mis),   32'd0);
        check_val("t1_flush", 32'(a_flush), 32'd0);
        tick();
        check_val("t1_beq",   32'(a_beq),   32'd1);
        check_val("t1_taken", 32'(a_taken), 32'h04);
        check_val("t1_bcnt",  32'(a_bcnt),  32'd1);
        check_val("t1_mcnt",  32'(a_mcnt),  32'd0);

        // 2: BNE predicted taken but not taken; following BEQ is squashed
        set_fetch(mk(OP_BNE, 5'd3, 16'h0008), 32'h100, 1'b1, 32'h120);
        tick();
        set_fetch(mk(OP_BEQ, 5'd3, 16'h0004), 32'h300, 1'b1, 32'h310);
        rs_val_d = 32'd7; rt_val_d = 32'd7; #1;
        check_val("t2_mis",   32'(a_mis),   32'd1);
        check_val("t2_redir", a_redir,      32'h100);
        check_val("t2_flush", 32'(a_flush), 32'd1);
        tick();
        valid_f = 1'b0; #1;
        check_val("t2_bne",    32'(a_bne),   32'd1);
        check_val("t2_taken",  32'(a_taken), 32'd0);
        check_val("t2_mcnt",   32'(a_mcnt),  32'd1);
        check_val("t2_bcnt",   32'(a_bcnt),  32'd2);
        check_val("t2_bubble", 32'(a_mis),   32'd0);
        tick();
        check_val("t2_sq_beq", 32'(a_beq),   32'd0);
        check_val("t2_sq_cnt", 32'(a_bcnt),  32'd2);

        // 3: BLTZ taken backwards to 0, predicted not taken
        set_fetch(mk(OP_REGIMM, 5'd0, 16'hFFFC), 32'h10, 1'b0, 32'h0);
        tick();
        valid_f = 1'b0; rs_val_d = 32'hFFFF_FFFF; #1;
        check_val("t3_mis",   32'(a_mis),   32'd1);
        check_val("t3_redir", a_redir,      32'h0);
        tick();
        check_val("t3_bltz",  32'(a_bltz),  32'd1);
        check_val("t3_taken", 32'(a_taken), 32'h02);
        check_val("t3_mcnt",  32'(a_mcnt),  32'd2);

        // 4: mispredicting BGTZ held under stall for 3 cycles
        set_fetch(mk(OP_BGTZ, 5'd0, 16'h0010), 32'h200, 1'b0, 32'h0);
        tick();
        valid_f = 1'b0; stall_d = 1'b1; rs_val_d = 32'd5; #1;
        for (int i = 0; i < 3; i++) begin
            check_val("t4_st_mis",   32'(a_mis),   32'd0);
            check_val("t4_st_flush", 32'(a_flush), 32'd0);
            check_val("t4_st_bgtz",  32'(a_bgtz),  32'd0);
            if (i < 2) tick();
        end
        tick();
        stall_d = 1'b0; #1;
        check_val("t4_mis",   32'(a_mis),   32'd1);
        check_val("t4_redir", a_redir,      32'h240);
        check_val("t4_flush", 32'(a_flush), 32'd1);
        tick();
        check_val("t4_bgtz",  32'(a_bgtz),  32'd1);
        check_val("t4_taken", 32'(a_taken), 32'h20);
        check_val("t4_bcnt",  32'(a_bcnt),  32'd4);
        check_val("t4_mcnt",  32'(a_mcnt),  32'd3);

        rst = 1'b0; tick(); rst = 1'b1; tick();

        // 5: FLUSH_CYCLES=3 window on instance B
        set_fetch(mk(OP_BEQ, 5'd3, 16'h0004), 32'h40, 1'b1, 32'h50);
        tick();
        set_fetch(mk(OP_BNE, 5'd3, 16'h0004), 32'h80, 1'b1, 32'h90);
        rs_val_d = 32'd1; rt_val_d = 32'd2; #1;
        check_val("t5_mis",    32'(b_mis),   32'd1);
        check_val("t5_redir",  b_redir,      32'h40);
        check_val("t5_flush0", 32'(b_flush), 32'd1);
        tick();
        check_val("t5_flush1", 32'(b_flush), 32'd1);
        check_val("t5_rc_mis", 32'(b_mis),   32'd0);
        check_val("t5_beq",    32'(b_beq),   32'd1);
        tick();
        check_val("t5_flush2", 32'(b_flush), 32'd1);
        check_val("t5_sq_bne", 32'(b_bne),   32'd0);
        valid_f = 1'b0;
        tick();
        check_val("t5_flush3", 32'(b_flush), 32'd0);
        tick();
        check_val("t5_bcnt",   32'(b_bcnt),  32'd1);
        check_val("t5_mcnt",   32'(b_mcnt),  32'd1);

        // 6a: asynchronous reset in the middle of RECOVER
        set_fetch(mk(OP_BEQ, 5'd3, 16'h0004), 32'h40, 1'b1, 32'h50);
        tick();
        valid_f = 1'b0; #1;
        check_val("t6_flush_m", 32'(b_flush), 32'd1);
        tick();
        check_val("t6_flush_r", 32'(b_flush), 32'd1);
        rst = 1'b0; #1;
        check_val("t6_rst_flush", 32'(b_flush), 32'd0);
        check_val("t6_rst_beq",   32'(b_beq),   32'd0);
        check_val("t6_rst_bcnt",  32'(b_bcnt),  32'd0);
        check_val("t6_rst_mcnt",  32'(b_mcnt),  32'd0);
        tick();
        rst = 1'b1;
        tick();
        check_val("t6_idle_flush", 32'(b_flush), 32'd0);

        // 6b: 20 correctly predicted branches back to back
        rs_val_d = 32'd3; rt_val_d = 32'd3;
        for (int i = 0; i < 20; i++) begin
            set_fetch(mk(OP_BEQ, 5'd3, 16'h0004), 32'h40, 1'b1, 32'h50);
            tick();
        end
        valid_f = 1'b0;
        tick(); tick();
        check_val("t6_sat_bcnt", 32'(b_bcnt), 32'd15);
        check_val("t6_sat_mcnt", 32'(b_mcnt), 32'd0);
        check_val("t6_a_bcnt",   32'(a_bcnt), 32'd20);
        check_val("t6_a_mcnt",   32'(a_mcnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
